// File: rtl/wash_timer_if.sv
// Handshake between the washer controller FSM and its timebase.
interface wash_timer_if #(
   parameter int STATE_W = 3
);
   logic [1:0]         clk_freq;
   logic [STATE_W-1:0] current_state;
   logic               pause;
   logic               minutes_1;
   logic               minutes_2;
   logic               minutes_5;
   logic [2:0]         elapsed_min;

   modport master (
      output clk_freq, current_state, pause,
      input  minutes_1, minutes_2, minutes_5, elapsed_min
   );

   modport slave (
      input  clk_freq, current_state, pause,
      output minutes_1, minutes_2, minutes_5, elapsed_min
   );
endinterface

// File: rtl/wash_timer.sv
// Per-state timebase for the washer FSM: ticks -> seconds -> minutes with
// one-cycle 1/2/5-minute strobes, cleared on state change or IDLE.
module wash_timer #(
   parameter int                 TICKS_BASE  = 1_000_000,
   parameter int                 SEC_PER_MIN = 60,
   parameter int                 STATE_W     = 3,
   parameter logic [STATE_W-1:0] IDLE_CODE   = '0
) (
   input  logic        clk,
   input  logic        rst,
   wash_timer_if.slave tif
);
   localparam int TW = $clog2(TICKS_BASE * 8);
   localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

   localparam logic [TW-1:0] TERM0    = TW'(TICKS_BASE - 1);
   localparam logic [TW-1:0] TERM1    = TW'(TICKS_BASE * 2 - 1);
   localparam logic [TW-1:0] TERM2    = TW'(TICKS_BASE * 4 - 1);
   localparam logic [TW-1:0] TERM3    = TW'(TICKS_BASE * 8 - 1);
   localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_MIN - 1);

   logic [TW-1:0]      tick_q, tick_d;
   logic [SW-1:0]      sec_q, sec_d;
   logic [2:0]         min_q, min_d;
   logic [STATE_W-1:0] state_q;
   logic               p1_q, p1_d, p2_q, p2_d, p5_q, p5_d;
   logic [TW-1:0]      term;
   logic               state_change;

   assign state_change = (tif.current_state != state_q);

   always_comb begin
      case (tif.clk_freq)
         2'b00:   term = TERM0;
         2'b01:   term = TERM1;
         2'b10:   term = TERM2;
         default: term = TERM3;
      endcase
   end

   always_comb begin
      tick_d = tick_q;
      sec_d  = sec_q;
      min_d  = min_q;
      p1_d   = 1'b0;
      p2_d   = 1'b0;
      p5_d   = 1'b0;
      if (state_change || (tif.current_state == IDLE_CODE)) begin
         tick_d = '0;
         sec_d  = '0;
         min_d  = '0;
      end else if (!tif.pause) begin
         // >= rather than == so a lowered clk_freq wraps an over-range count
         if (tick_q >= term) begin
            tick_d = '0;
            if (sec_q == SEC_LAST) begin
               sec_d = '0;
               if (min_q != 3'd7) min_d = min_q + 3'd1;
               p1_d = (min_q == 3'd0);
               p2_d = (min_q == 3'd1);
               p5_d = (min_q == 3'd4);
            end else begin
               sec_d = sec_q + SW'(1);
            end
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q  <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         state_q <= IDLE_CODE;
         p1_q    <= 1'b0;
         p2_q    <= 1'b0;
         p5_q    <= 1'b0;
      end else begin
         tick_q  <= tick_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         state_q <= tif.current_state;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         p5_q    <= p5_d;
      end
   end

   // Mask strobes while the FSM has already moved on to a new state
   assign tif.minutes_1   = p1_q & ~state_change;
   assign tif.minutes_2   = p2_q & ~state_change;
   assign tif.minutes_5   = p5_q & ~state_change;
   assign tif.elapsed_min = min_q;
endmodule

// File: doc/wash_timer.md
Name: wash_timer

Overview:
- Upstream timebase for the washing-machine controller FSM.
- Divides the system clock to seconds and minutes according to the clk_freq setting, and measures time spent in the FSM's current state.
- Emits one-cycle minutes_1 / minutes_2 / minutes_5 strobes, which the FSM uses for its phase transitions.
- Restarts timing on every FSM state change, freezes while paused, and stays cleared while the FSM is IDLE.

Parameters:
- TICKS_BASE, 1_000_000: clk cycles per second when clk_freq=2'b00. Cycles per second = TICKS_BASE << clk_freq, i.e. 1/2/4/8 MHz.
- SEC_PER_MIN, 60: seconds per minute. Reduced only for simulation.
- STATE_W, 3: width of the FSM state encoding.
- IDLE_CODE, 3'b000: FSM state code for which the timer is held cleared.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- clk_freq  in  2  clock frequency select: 00=1x, 01=2x, 10=4x, 11=8x TICKS_BASE
- current_state  in  STATE_W  registered state from the controller FSM
- pause  in  1  1 = freeze all timing
- minutes_1  out  1  one-cycle strobe: 1 minute elapsed in the current state
- minutes_2  out  1  one-cycle strobe: 2 minutes elapsed in the current state
- minutes_5  out  1  one-cycle strobe: 5 minutes elapsed in the current state
- elapsed_min  out  3  whole minutes in the current state, saturating at 7

Behaviour:
- **Reset (rst=0, async):**
  - tick_cnt=0, sec_cnt=0, min_cnt=0.
  - state_q=IDLE_CODE.
  - All strobe registers=0, so all outputs=0.
- **Registers:**
  - tick_cnt: width clog2(TICKS_BASE*8).
  - sec_cnt: 0..SEC_PER_MIN-1.
  - min_cnt: 3 bits, saturating.
  - state_q: last sampled current_state.
  - p1_q, p2_q, p5_q: strobe registers.
- **state_change** = (current_state != state_q), combinational. state_q <= current_state every cycle.
- **Priority per edge (highest first):**
  1. state_change or current_state==IDLE_CODE: clear tick/sec/min counters and strobe registers.
  2. pause=1: hold all counters; strobe registers <= 0.
  3. Count.
- **Count:**
  - term = (TICKS_BASE << clk_freq) - 1.
  - If tick_cnt >= term: tick_cnt <= 0 and a second elapses; otherwise tick_cnt++.
  - The >= comparison absorbs a mid-count clk_freq decrease. The wrap takes effect on the next edge, with no overrun.
  - On a second: if sec_cnt == SEC_PER_MIN-1, then sec_cnt <= 0 and min_cnt <= sat(min_cnt+1); otherwise sec_cnt++.
  - Strobes: on the edge where min_cnt goes 0→1, p1_q <= 1; 1→2 sets p2_q; 4→5 sets p5_q. All other edges clear them, so each strobe is exactly 1 cycle.
  - Saturation at 7 produces no further strobes.
- **Outputs:**
  - minutes_N = pN_q & ~state_change. This guarantees that a strobe registered in the old state is never seen by the FSM in its new state.
  - elapsed_min = min_cnt (registered).
- **Latency:**
  - Minute N in a state is reached (N*SEC_PER_MIN*(term+1)) cycles after the first counting edge.
  - The first counting edge is the edge after state_q catches up, i.e. the second edge after the FSM changes state.
  - The strobe is visible in the following cycle.
- **Pause:**
  - Pausing is lossless: timing resumes from the exact tick_cnt on release.
  - A strobe due on a paused edge is not issued. The crossing happens only when counting.
- **Boundary conditions:**
  - A clk_freq change mid-minute applies from the next tick comparison. Elapsed ticks are kept, not rescaled.
  - A rinse→wash re-entry via double_wash is a state change, so the timer restarts from 0.
  - Reset asserted mid-operation clears everything immediately. After release, counting starts only once current_state is non-IDLE.

Test Plan (TICKS_BASE=2, SEC_PER_MIN=3, so 6 cycles/min at clk_freq=00):
- Reset then current_state 0→1, clk_freq=00, pause=0 → minutes_1 high exactly 1 cycle at 7 cycles after state_q update, minutes_2 at 13, elapsed_min=2; minutes_5 at 31 if state held.
- clk_freq=11 (16 ticks/s) in state 2 → minutes_1 at 48 cycles after counting begins; minutes_5 at 240; elapsed_min saturates 7 at 336, with no further strobes.
- pause=1 for 20 cycles at tick 3 of minute 0 → no strobe during pause; minutes_1 arrives exactly 20 cycles later than the unpaused case.
- State 2→3 on the same cycle a p2_q strobe is registered → minutes_2 output stays 0; counters restart and elapsed_min=0 next cycle.
- current_state held at IDLE for 100 cycles → all outputs 0, elapsed_min=0; rst pulsed low mid-minute in state 1 → outputs 0 asynchronously, and the count restarts from 0.
- clk_freq switched 11→00 with tick_cnt=10 (>term=1) → tick_cnt wraps to 0 on the next edge and a second counts; no counter overflow.
